// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the symbol-sequence detector.
// Holds the detector state enum, the default pattern and the slot-index width helper.
package seq_det_pkg;

  typedef enum logic {
    FILL,
    ARMED
  } seq_state_e;

  localparam logic [15:0] SEQ_DET_PATTERN_DFLT = 16'h4210;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// seq_det_hist: shift register of the last SEQ_LEN-1 accepted symbols plus fill count.
// Ports: clk_i, rst_n_i, shift_i (accepted symbol), flush_i, hold_i, sym_i;
//        hist_o (slot 0 = oldest), armed_o (fill reached SEQ_LEN-1).
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 4,
  parameter int SEQ_LEN = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          shift_i,
  input  logic                          flush_i,
  input  logic                          hold_i,
  input  logic [SYM_W-1:0]              sym_i,
  output logic [SEQ_LEN-2:0][SYM_W-1:0] hist_o,
  output logic                          armed_o
);

  localparam int FILL_W = idx_w(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN - 1);

  logic [SEQ_LEN-2:0][SYM_W-1:0] hist_q;
  logic [FILL_W-1:0]             fill_q;

  // Flush wins over shift: a flushing cycle never keeps its own symbol.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (flush_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_i && !hold_i) begin
      for (int i = 0; i < SEQ_LEN - 2; i++) begin
        hist_q[i] <= hist_q[i+1];
      end
      hist_q[SEQ_LEN-2] <= sym_i;
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  assign hist_o  = hist_q;
  assign armed_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/seq_detector.sv
// seq_detector: runtime-programmable detector of the last SEQ_LEN accepted symbols.
// Ports: clk_i, rst_n_i, valid_i, data_i, overlap_i, cfg_we_i/cfg_idx_i/cfg_sym_i
//        (pattern write), cnt_clr_i; found_o pulse, match_cnt_o.
//        Macro SEQ_DETECTOR_CNT_EN enables the saturating match counter.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 4,
  parameter int SEQ_LEN = 4,
  parameter logic [SEQ_LEN*SYM_W-1:0] PATTERN_RST =
    (SEQ_LEN*SYM_W)'(SEQ_DET_PATTERN_DFLT),
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      valid_i,
  input  logic [SYM_W-1:0]          data_i,
  input  logic                      overlap_i,
  input  logic                      cfg_we_i,
  input  logic [idx_w(SEQ_LEN)-1:0] cfg_idx_i,
  input  logic [SYM_W-1:0]          cfg_sym_i,
  input  logic                      cnt_clr_i,
  output logic                      found_o,
  output logic [CNT_W-1:0]          match_cnt_o
);

  localparam int IDX_W = idx_w(SEQ_LEN);
  localparam logic [IDX_W:0] SLOTS = (IDX_W+1)'(SEQ_LEN);

  logic [SEQ_LEN-1:0][SYM_W-1:0] pat_q;
  logic [SEQ_LEN-2:0][SYM_W-1:0] hist;
  logic                          armed;
  seq_state_e                    state;
  logic                          accept;
  logic                          wr_ok;
  logic                          hist_eq;
  logic                          match;
  logic                          flush;
  logic                          found_q;

  // A write always steals the cycle; only an in-range write touches state.
  assign accept = valid_i & ~cfg_we_i;
  assign wr_ok  = cfg_we_i & ({1'b0, cfg_idx_i} < SLOTS);
  assign state  = armed ? ARMED : FILL;

  always_comb begin
    hist_eq = 1'b1;
    for (int i = 0; i < SEQ_LEN - 1; i++) begin
      if (hist[i] != pat_q[i]) begin
        hist_eq = 1'b0;
      end
    end
  end

  assign match = accept
               & (state == ARMED)
               & hist_eq
               & (data_i == pat_q[SEQ_LEN-1]);

  // Non-overlap restarts collection from scratch after a hit.
  assign flush = wr_ok | (match & ~overlap_i);

  seq_det_hist #(
    .SYM_W   (SYM_W),
    .SEQ_LEN (SEQ_LEN)
  ) u_hist (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .shift_i (accept),
    .flush_i (flush),
    .hold_i  (~valid_i),
    .sym_i   (data_i),
    .hist_o  (hist),
    .armed_o (armed)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pat_q   <= PATTERN_RST;
      found_q <= 1'b0;
    end else begin
      found_q <= match;
      if (wr_ok) begin
        pat_q[cfg_idx_i] <= cfg_sym_i;
      end
    end
  end

  assign found_o = found_q;

`ifdef SEQ_DETECTOR_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear beats increment, but a same-cycle hit still counts as one.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt_o = cnt_q;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr_i;
  assign match_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed stimulus with expected pulses queued for a monitor.
// Two instances share stimulus: CNT_W=16 and CNT_W=2 (saturation).
module tb_seq_detector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  data = '0;
  logic        ovl = 1'b1;
  logic        we = 1'b0;
  logic [1:0]  idx = '0;
  logic [3:0]  sym = '0;
  logic        clr = 1'b0;
  logic        found_a;
  logic        found_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  typedef struct {
    int cyc;
    int c16;
    int c2;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   ncmp = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   cnt16 = 0;
  int   cnt2 = 0;

  seq_detector #(.CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid),
    .data_i      (data),
    .overlap_i   (ovl),
    .cfg_we_i    (we),
    .cfg_idx_i   (idx),
    .cfg_sym_i   (sym),
    .cnt_clr_i   (clr),
    .found_o     (found_a),
    .match_cnt_o (cnt_a)
  );

  seq_detector #(.CNT_W(2)) dut_s (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid),
    .data_i      (data),
    .overlap_i   (ovl),
    .cfg_we_i    (we),
    .cfg_idx_i   (idx),
    .cfg_sym_i   (sym),
    .cnt_clr_i   (clr),
    .found_o     (found_b),
    .match_cnt_o (cnt_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ecnt(input int n);
`ifdef SEQ_DETECTOR_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int got, input int req);
    ncmp++;
    if (got != req) begin
      nerr++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // One input cycle; m marks a hand-computed match on this symbol.
  task automatic step(input logic v, input logic [3:0] d,
                      input logic m, input logic c);
    @(negedge clk);
    valid = v;
    data  = d;
    we    = 1'b0;
    clr   = c;
    if (c) begin
      cnt16 = m ? 1 : 0;
      cnt2  = m ? 1 : 0;
    end else if (m) begin
      cnt16 = cnt16 + 1;
      cnt2  = (cnt2 == 3) ? 3 : cnt2 + 1;
    end
    if (m) exp_q.push_back('{cyc + 1, ecnt(cnt16), ecnt(cnt2)});
  endtask

  task automatic wr(input logic [1:0] i, input logic [3:0] s,
                    input logic v, input logic [3:0] d);
    @(negedge clk);
    we    = 1'b1;
    idx   = i;
    sym   = s;
    valid = v;
    data  = d;
    clr   = 1'b0;
  endtask

  task automatic seq4(input logic m);
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd2, 0, 0);
    step(1, 4'd4, m, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ncmp++;
        nerr++;
        $display("FAIL missing_pulse found_o=0 required=1 cycle=%0d",
                 exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (found_a) begin
        ncmp++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          if (int'(cnt_a) != e.c16 || int'(cnt_b) != e.c2 || !found_b) begin
            nerr++;
            $display("FAIL match_cnt cyc=%0d got=%0d/%0d/%b required=%0d/%0d/1",
                     cyc, cnt_a, cnt_b, found_b, e.c16, e.c2);
          end
        end else begin
          nerr++;
          $display("FAIL unexpected_pulse found_o=1 required=0 cycle=%0d", cyc);
        end
      end
    end
  end

  initial begin
    #1;
    chk("rst_found", int'(found_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset pattern 0,1,2,4 in overlap mode.
    seq4(1);
    step(0, 4'd0, 0, 0);

    // Pattern 3,3,3,3, overlapping: hits on symbols 4..7.
    wr(0, 4'd3, 0, 4'd0);
    wr(1, 4'd3, 0, 4'd0);
    wr(2, 4'd3, 0, 4'd0);
    wr(3, 4'd3, 0, 4'd0);
    step(0, 4'd0, 0, 1);
    for (int i = 1; i <= 7; i++) step(1, 4'd3, i >= 4, 0);

    // Non-overlapping: hits on symbols 4 and 8 only.
    wr(0, 4'd3, 0, 4'd0);
    ovl = 1'b0;
    step(0, 4'd0, 0, 1);
    for (int i = 1; i <= 8; i++) step(1, 4'd3, i == 4 || i == 8, 0);

    // Restore 0,1,2,4; gaps of valid_i=0 do not break the sequence.
    ovl = 1'b1;
    wr(0, 4'd0, 0, 4'd0);
    wr(1, 4'd1, 0, 4'd0);
    wr(2, 4'd2, 0, 4'd0);
    wr(3, 4'd4, 0, 4'd0);
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 4'd9, 0, 0);
    step(1, 4'd2, 0, 0);
    step(1, 4'd4, 1, 0);

    // Write on the final symbol drops it and flushes.
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd2, 0, 0);
    wr(3, 4'd4, 1, 4'd4);
    seq4(1);
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd2, 0, 0);
    step(1, 4'd3, 0, 0);
    seq4(1);

    // Saturation on the 2-bit counter, then clear together with a hit.
    step(0, 4'd0, 0, 1);
    for (int i = 0; i < 5; i++) seq4(1);
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd2, 0, 0);
    step(1, 4'd4, 1, 1);
    step(0, 4'd0, 0, 0);

    // Asynchronous reset mid-sequence also restores the pattern.
    wr(3, 4'd7, 0, 4'd0);
    step(1, 4'd0, 0, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd2, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("async_rst_found", int'(found_a), 0);
    chk("async_rst_cnt16", int'(cnt_a), 0);
    chk("async_rst_cnt2", int'(cnt_b), 0);
    cnt16 = 0;
    cnt2  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'd4, 0, 0);
    seq4(1);

    step(0, 4'd0, 0, 0);
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      ncmp++;
      nerr++;
      $display("FAIL pending_pulse found_o=0 required=1 cycle=%0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised, runtime-programmable symbol-sequence detector; the next generation of the fixed 4-bit `fsm` pattern detector. It samples a qualified symbol stream, compares the last `SEQ_LEN` accepted symbols against a writable pattern register, and pulses `found_o` on a match. It supports overlapping and non-overlapping match modes and an optional saturating match counter. It sits directly on the symbol stream feeding downstream protocol logic.

## Interface
- `SYM_W`, default 4: symbol width in bits.
- `SEQ_LEN`, default 4: pattern length in symbols, minimum 2.
- `PATTERN_RST`, default `16'h4210`: reset pattern, flat `SEQ_LEN*SYM_W` bits. Symbol 0 is in bits `[SYM_W-1:0]` and is the first to arrive. The default pattern is 0,1,2,4.
- `CNT_W`, default 16: match counter width.
- `clk_i` in 1: single clock, all logic on its rising edge.
- `rst_n_i` in 1: reset. Asynchronous, active-low.
- `valid_i` in 1: `data_i` is a symbol this cycle.
- `data_i` in `SYM_W`: incoming symbol.
- `overlap_i` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `cfg_we_i` in 1: pattern write strobe.
- `cfg_idx_i` in `$clog2(SEQ_LEN)`: pattern slot to write.
- `cfg_sym_i` in `SYM_W`: symbol value to write.
- `cnt_clr_i` in 1: synchronous clear of the match counter.
- `found_o` out 1: registered one-cycle match pulse.
- `match_cnt_o` out `CNT_W`: saturating match count.

## Operation
- **History:** shift register of the last `SEQ_LEN-1` accepted symbols, plus a fill counter with range 0..`SEQ_LEN-1`. Accepted means `valid_i=1` and `cfg_we_i=0`.
- **States:**
  - FILL: fill < `SEQ_LEN-1`. Each accepted symbol shifts in and increments fill.
  - ARMED: fill = `SEQ_LEN-1`. Each accepted symbol is compared together with the history against the pattern; the history shifts and fill holds.
  - Transitions:
    - FILL→ARMED when fill reaches `SEQ_LEN-1`.
    - ARMED→FILL with fill=0 on a match when `overlap_i=0`.
    - Any state→FILL with fill=0 on a pattern write.
- **Match:** in ARMED, the accepted `data_i` equals pattern[`SEQ_LEN-1`] and history[i] equals pattern[i] for all i. On a match, `found_o` is set at that edge.
- **Overlap mode:** after a match the history keeps its contents, so the suffix of a match can start the next one.
- **Pattern write:**
  - `cfg_we_i=1` writes `cfg_sym_i` into slot `cfg_idx_i`.
  - An index ≥ `SEQ_LEN` is ignored, with no flush.
  - A valid write flushes the history (fill=0).
  - The write has priority: a `valid_i` symbol in the same cycle is dropped.
- **`valid_i=0`:** history, fill and state hold; `found_o` drops.
- **Counter:** increments by 1 on each match and saturates at all-ones. If `cnt_clr_i` and a match occur in the same cycle, the counter loads 1. `cnt_clr_i` alone loads 0.
- **Mode change:** `overlap_i` is sampled each cycle. A change takes effect on the next match and does not flush the history.

## Timing
- **Reset values:**
  - `found_o`=0, `match_cnt_o`=0.
  - fill=0, state FILL, history all zero.
  - pattern=`PATTERN_RST`.
- **Reset mid-operation:** asynchronous. Everything above returns to its reset value immediately, including any runtime-written pattern.
- **Latency:** the final symbol is sampled at edge k, and `found_o` is high from k until k+1. `match_cnt_o` updates at the same edge k.
- **Pulse width:** `found_o` is a single-cycle pulse per match. Back-to-back matches on consecutive edges give `found_o` high on consecutive cycles. This is possible only in overlap mode with a periodic pattern, e.g. all-equal symbols.
- **First match:** in non-overlap mode or after a flush, the first match needs at least `SEQ_LEN` accepted symbols after the flush.
- **Pattern write timing:** a write at edge k is used in comparisons from edge k+1.

## Configuration
- Macro `SEQ_DETECTOR_CNT_EN`.
- **Defined:** the match counter and `cnt_clr_i` behave as above.
- **Undefined:**
  - No counter flops.
  - `match_cnt_o` is tied to 0 and `cnt_clr_i` is ignored.
  - `found_o` behaviour is unchanged.

## Structure
- Package `seq_det_pkg`:
  - State enum {FILL, ARMED}.
  - Default pattern constant `SEQ_DET_PATTERN_DFLT` = `16'h4210`.
  - Helper function for the slot-index width.
- Sub-module `seq_det_hist`: history shift register and fill counter. Inputs are shift, flush and hold controls; outputs are the history vector and an `armed` flag.
- Top level: pattern register, comparator, state transitions, `found_o` register and the optional counter.

## Test plan
- Reset pattern, overlap=1, stream 0,1,2,4 with `valid_i` held high → `found_o` high for exactly one cycle after the edge sampling the 4; count=1.
- Write pattern 3,3,3,3, then stream seven 3s:
  - overlap=1 → matches on symbols 4,5,6,7, count=4.
  - overlap=0 → match on symbol 4 only, count=1.
- Stream 0,1 then `valid_i` low for 5 cycles, then 2,4 → match on the 4; gaps do not break the sequence.
- Pattern write at the same edge as the final symbol 4 of 0,1,2,4 → no match, the symbol is dropped and the history is flushed. A following 0,1,2,4 with the unchanged pattern matches after 4 symbols.
- `CNT_W`=2, 5 matches → count saturates at 3. Then `cnt_clr_i` together with a match → count=1.
- Reset asserted mid-sequence after 0,1,2 → outputs are 0 immediately. After reset release, 4 alone gives no match, and a full 0,1,2,4 matches.
